hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Sits beside the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for the 5-stage MIPS core. It sits beside the IF/ID and
//   ID/EX pipeline registers and does three things:
//     - detects load-use hazards and inserts a single-cycle bubble,
//     - flushes the front end on a taken branch resolved in EX,
//     - freezes the front end while a multi-cycle EX op (mult/div) runs.
//   It also keeps a saturating count of the cycles in which the PC was frozen.
//
// Parameters
//   MC_CYCLES  total EX-stage cycles of a multi-cycle op (>= 2)
//   CNT_W      width of the stall-cycle counter
//
// Ports
//   Clk_in             clock, all state updates on the rising edge
//   Reset_n_in         asynchronous active-low reset
//   IFID_rs_in/rt_in   source register fields of the instruction in ID
//   IFID_UsesRs/Rt_in  ID instruction actually reads rs / rt
//   IDEX_MemRead_in    instruction in EX is a load
//   IDEX_rt_in         destination register of that load
//   IDEX_MultiCycle_in instruction in EX is a multi-cycle op
//   BranchTaken_in     branch in EX resolved taken this cycle
//   PCWrite_out        PC may update
//   IFIDWrite_out      IF/ID may load
//   IFIDFlush_out      IF/ID loads a NOP
//   IDEXBubble_out     ID/EX loads all-zero control fields
//   IDEXHold_out       ID/EX keeps its contents
//   StallCount_out     saturating count of cycles with PCWrite_out low
//   Busy_out           sequencer is waiting on a multi-cycle op
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int MC_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic             Clk_in,
   input  logic             Reset_n_in,
   input  logic [4:0]       IFID_rs_in,
   input  logic [4:0]       IFID_rt_in,
   input  logic             IFID_UsesRs_in,
   input  logic             IFID_UsesRt_in,
   input  logic             IDEX_MemRead_in,
   input  logic [4:0]       IDEX_rt_in,
   input  logic             IDEX_MultiCycle_in,
   input  logic             BranchTaken_in,
   output logic             PCWrite_out,
   output logic             IFIDWrite_out,
   output logic             IFIDFlush_out,
   output logic             IDEXBubble_out,
   output logic             IDEXHold_out,
   output logic [CNT_W-1:0] StallCount_out,
   output logic             Busy_out
);

   localparam int MCW = $clog2(MC_CYCLES);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MC_BUSY = 1'b1;

   // mc_cnt holds the number of MC_BUSY cycles still to run, including the
   // current one. The RUN detect cycle accounts for one EX cycle and the last
   // EX cycle overlaps the first RUN cycle afterwards, so MC_BUSY lasts
   // MC_CYCLES-2 cycles and the whole freeze is MC_CYCLES-1 cycles.
   localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_CYCLES - 2);

   logic [0:0]       state_q, state_d;
   logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use;
   logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, busy;

   assign load_use = IDEX_MemRead_in && (IDEX_rt_in != 5'd0) &&
                     ((IFID_UsesRs_in && (IDEX_rt_in == IFID_rs_in)) ||
                      (IFID_UsesRt_in && (IDEX_rt_in == IFID_rt_in)));

   always_comb begin
      state_d     = state_q;
      mc_cnt_d    = mc_cnt_q;
      done_d      = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_hold   = 1'b0;
      busy        = 1'b0;
      case (state_q)
         RUN: begin
            if (BranchTaken_in) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (IDEX_MultiCycle_in && !done_q) begin
               // done_q masks the op that just finished and is still held in EX
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_hold  = 1'b1;
               if (MC_CYCLES == 2) begin
                  // the detect cycle alone covers the op
                  done_d = 1'b1;
               end else begin
                  state_d  = MC_BUSY;
                  mc_cnt_d = MC_LOAD;
               end
            end else if (load_use) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
         end
         MC_BUSY: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            busy       = 1'b1;
            if (mc_cnt_q <= MCW'(1)) begin
               state_d  = RUN;
               mc_cnt_d = '0;
               done_d   = 1'b1;
            end else begin
               mc_cnt_d = mc_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = RUN;
            mc_cnt_d = '0;
         end
      endcase
   end

   assign stall_d = (!pc_write && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;

   always_ff @(posedge Clk_in or negedge Reset_n_in) begin
      if (!Reset_n_in) begin
         state_q  <= RUN;
         mc_cnt_q <= '0;
         done_q   <= 1'b0;
         stall_q  <= '0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
         done_q   <= done_d;
         stall_q  <= stall_d;
      end
   end

   // While reset is held the registers are already cleared, but live inputs
   // could still look like a hazard, so the outputs are forced to free-run.
   assign PCWrite_out    = pc_write    | ~Reset_n_in;
   assign IFIDWrite_out  = ifid_write  | ~Reset_n_in;
   assign IFIDFlush_out  = ifid_flush  & Reset_n_in;
   assign IDEXBubble_out = idex_bubble & Reset_n_in;
   assign IDEXHold_out   = idex_hold   & Reset_n_in;
   assign Busy_out       = busy        & Reset_n_in;
   assign StallCount_out = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  ifid_rs, ifid_rt, idex_rt;
   logic        uses_rs, uses_rt, mem_read, multi, branch;

   logic        pcw, ifw, flush, bubble, hold, busy;
   logic [15:0] cnt16;
   logic        pcw4, ifw4, flush4, bubble4, hold4, busy4;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .Clk_in(clk), .Reset_n_in(rst_n),
      .IFID_rs_in(ifid_rs), .IFID_rt_in(ifid_rt),
      .IFID_UsesRs_in(uses_rs), .IFID_UsesRt_in(uses_rt),
      .IDEX_MemRead_in(mem_read), .IDEX_rt_in(idex_rt),
      .IDEX_MultiCycle_in(multi), .BranchTaken_in(branch),
      .PCWrite_out(pcw), .IFIDWrite_out(ifw), .IFIDFlush_out(flush),
      .IDEXBubble_out(bubble), .IDEXHold_out(hold),
      .StallCount_out(cnt16), .Busy_out(busy)
   );

   hazard_ctrl #(.MC_CYCLES(4), .CNT_W(4)) dut_sat (
      .Clk_in(clk), .Reset_n_in(rst_n),
      .IFID_rs_in(ifid_rs), .IFID_rt_in(ifid_rt),
      .IFID_UsesRs_in(uses_rs), .IFID_UsesRt_in(uses_rt),
      .IDEX_MemRead_in(mem_read), .IDEX_rt_in(idex_rt),
      .IDEX_MultiCycle_in(multi), .BranchTaken_in(branch),
      .PCWrite_out(pcw4), .IFIDWrite_out(ifw4), .IFIDFlush_out(flush4),
      .IDEXBubble_out(bubble4), .IDEXHold_out(hold4),
      .StallCount_out(cnt4), .Busy_out(busy4)
   );

   // expected control vector {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, Busy}
   localparam logic [5:0] E_NORM = 6'b110000;
   localparam logic [5:0] E_LU   = 6'b000100;
   localparam logic [5:0] E_BR   = 6'b111100;
   localparam logic [5:0] E_MCR  = 6'b000010;
   localparam logic [5:0] E_MCB  = 6'b000011;

   typedef struct packed {
      logic [5:0]  ctl;
      logic [15:0] c16;
      logic [3:0]  c4;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m16 = 0;
   int          m4  = 0;

   task automatic clear_inputs();
      ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
      uses_rs = 1'b0; uses_rt = 1'b0; mem_read = 1'b0;
      multi = 1'b0; branch = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] ldrt, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt);
      mem_read = 1'b1; idex_rt = ldrt; ifid_rs = rs; ifid_rt = rt;
      uses_rs = urs; uses_rt = urt;
   endtask

   task automatic compare(input string name);
      exp_t e;
      logic [5:0] act, act4;
      e    = sb.pop_front();
      act  = {pcw, ifw, flush, bubble, hold, busy};
      act4 = {pcw4, ifw4, flush4, bubble4, hold4, busy4};
      n_checks += 4;
      if (act !== e.ctl) begin
         n_fail++;
         $display("FAIL %s ctl: got %b expected %b", name, act, e.ctl);
      end
      if (act4 !== e.ctl) begin
         n_fail++;
         $display("FAIL %s ctl_sat: got %b expected %b", name, act4, e.ctl);
      end
      if (cnt16 !== e.c16) begin
         n_fail++;
         $display("FAIL %s stallcount: got %0d expected %0d", name, cnt16, e.c16);
      end
      if (cnt4 !== e.c4) begin
         n_fail++;
         $display("FAIL %s stallcount_sat: got %0d expected %0d", name, cnt4, e.c4);
      end
      $display("%0t %s ctl=%b cnt=%0d cnt4=%0d", $time, name, act, cnt16, cnt4);
   endtask

   // inputs are already applied (posedge+1); check mid-cycle, then advance
   task automatic step(input logic [5:0] ctl, input string name);
      sb.push_back('{ctl: ctl, c16: 16'(m16), c4: 4'(m4)});
      @(negedge clk);
      compare(name);
      if (ctl[5] == 1'b0) begin
         if (m16 < 65535) m16++;
         if (m4 < 15) m4++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m16 = 0; m4 = 0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      multi = 1'b1;
      rst_n = 1'b0;
      #2;
      sb.push_back('{ctl: E_NORM, c16: 16'd0, c4: 4'd0});
      compare("reset_hold");
      @(posedge clk);
      #1;
      sb.push_back('{ctl: E_NORM, c16: 16'd0, c4: 4'd0});
      compare("reset_after_edge");
      clear_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(E_NORM, "reset_released");
   endtask

   task automatic test_load_use();
      clear_inputs();
      set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      step(E_LU, "lu_rs");
      clear_inputs();
      step(E_NORM, "lu_rs_after");
      set_load_use(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
      step(E_LU, "lu_rt");
      clear_inputs();
      step(E_NORM, "lu_rt_after");
      set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      step(E_NORM, "lu_r0");
      set_load_use(5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
      step(E_NORM, "lu_unused");
      set_load_use(5'd7, 5'd3, 5'd4, 1'b1, 1'b1);
      step(E_NORM, "lu_nomatch");
      set_load_use(5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
      mem_read = 1'b0;
      step(E_NORM, "lu_not_load");
      clear_inputs();
   endtask

   task automatic test_branch();
      clear_inputs();
      branch = 1'b1;
      step(E_BR, "branch");
      set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      step(E_BR, "branch_vs_lu");
      multi = 1'b1;
      step(E_BR, "branch_vs_mc");
      clear_inputs();
      step(E_NORM, "branch_after");
   endtask

   task automatic test_multicycle();
      clear_inputs();
      multi = 1'b1;
      step(E_MCR, "mc_detect");
      step(E_MCB, "mc_busy1");
      step(E_MCB, "mc_busy2");
      step(E_NORM, "mc_done_masked");
      multi = 1'b0;
      step(E_NORM, "mc_after");
   endtask

   task automatic test_branch_in_busy();
      clear_inputs();
      multi = 1'b1;
      step(E_MCR, "mcbr_detect");
      branch = 1'b1;
      set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      step(E_MCB, "mcbr_busy1");
      step(E_MCB, "mcbr_busy2");
      clear_inputs();
      step(E_NORM, "mcbr_done");
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      set_load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
      step(E_LU, "b2b_lu");
      clear_inputs();
      multi = 1'b1;
      step(E_MCR, "b2b_mc");
      multi = 1'b0;
      step(E_MCB, "b2b_busy1");
      step(E_MCB, "b2b_busy2");
      // a fresh multi-cycle op right after the masked cycle starts again
      multi = 1'b1;
      step(E_NORM, "b2b_masked");
      step(E_MCR, "b2b_retrig");
      multi = 1'b0;
      step(E_MCB, "b2b_busy3");
      step(E_MCB, "b2b_busy4");
      step(E_NORM, "b2b_end");
   endtask

   task automatic test_reset_mid_busy();
      clear_inputs();
      multi = 1'b1;
      step(E_MCR, "rmb_detect");
      rst_n = 1'b0;
      m16 = 0; m4 = 0;
      #1;
      sb.push_back('{ctl: E_NORM, c16: 16'd0, c4: 4'd0});
      compare("rmb_reset");
      #1;
      clear_inputs();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(E_NORM, "rmb_run");
      step(E_NORM, "rmb_run2");
   endtask

   task automatic test_saturation();
      clear_inputs();
      do_reset();
      set_load_use(5'd6, 5'd6, 5'd6, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step(E_LU, "sat_stall");
      clear_inputs();
      step(E_NORM, "sat_hold");
      if (m4 != 15) begin
         n_fail++;
         $display("FAIL sat_model: model count %0d required 15", m4);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b1;
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_branch_in_busy();
      test_back_to_back();
      test_reset_mid_busy();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required completion before 100000");
      $fatal(1, "timeout");
   end

endmodule
